// File: rtl/jt6295_rom_arb.sv
// jt6295_rom_arb
// Shares the single external ADPCM sample ROM port between the phrase-table
// controller and the four per-channel sample fetchers. The controller has
// fixed priority. The channels are served round-robin. Each access waits
// out one guard cycle before it trusts rom_ok, because rom_ok may still
// describe the previous address. The returned byte goes back to the winner
// together with a one-cycle ok pulse.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   ctrl_cs/ctrl_addr    phrase-table read request (level) and 10-bit address
//   ctrl_ok              one-cycle pulse, controller read done, dout valid
//   ch_cs/ch_addr        per-channel requests, ch n address at [18n+17:18n]
//   ch_ok                one-cycle pulse per channel, read done, dout valid
//   dout                 returned byte, held until the next completion
//   rom_addr/rom_cs      external ROM address and select
//   rom_data/rom_ok      external ROM data and its valid flag
//
// Configuration
//   JT6295_ROM_CACHE_EN  when defined, each channel keeps a one-entry cache
//                        (tag, byte, valid). A hit completes straight from
//                        IDLE without touching the ROM.
module jt6295_rom_arb (
   input  logic        clk,
   input  logic        rst,
   input  logic        ctrl_cs,
   input  logic [9:0]  ctrl_addr,
   output logic        ctrl_ok,
   input  logic [3:0]  ch_cs,
   input  logic [71:0] ch_addr,
   output logic [3:0]  ch_ok,
   output logic [7:0]  dout,
   output logic [17:0] rom_addr,
   output logic        rom_cs,
   input  logic [7:0]  rom_data,
   input  logic        rom_ok
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic        rom_cs_q, rom_cs_d;
   logic [17:0] rom_addr_q, rom_addr_d;
   logic [7:0]  dout_q, dout_d;
   logic        ctrl_ok_q, ctrl_ok_d;
   logic [3:0]  ch_ok_q, ch_ok_d;
   logic [1:0]  rr_q, rr_d;
   logic        guard_q, guard_d;
   logic        gnt_ctrl_q, gnt_ctrl_d;
   logic [1:0]  gnt_ch_q, gnt_ch_d;

   logic [17:0] ch_addr_arr [4];
   logic        ch_any;
   logic [1:0]  ch_sel;
   logic        gnt_dropped;

`ifdef JT6295_ROM_CACHE_EN
   logic [17:0] tag_q [4], tag_d [4];
   logic [7:0]  cdata_q [4], cdata_d [4];
   logic [3:0]  cvalid_q, cvalid_d;
   logic        cache_hit;
`endif

   // Unpack the channel address bus into one entry per channel.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         ch_addr_arr[i] = ch_addr[18*i +: 18];
      end
   end

   // Round-robin search from rr+1 up to rr. The loop runs backwards, so the
   // nearest requester after rr is written last and therefore wins.
   always_comb begin
      ch_any = 1'b0;
      ch_sel = rr_q;
      for (int i = 4; i >= 1; i--) begin
         if (ch_cs[rr_q + 2'(i)]) begin
            ch_any = 1'b1;
            ch_sel = rr_q + 2'(i);
         end
      end
   end

   // An access is abandoned as soon as its own requester lets go of cs.
   assign gnt_dropped = gnt_ctrl_q ? !ctrl_cs : !ch_cs[gnt_ch_q];

`ifdef JT6295_ROM_CACHE_EN
   assign cache_hit = cvalid_q[ch_sel] && (tag_q[ch_sel] == ch_addr_arr[ch_sel]);
`endif

   // Next-state and output logic. Every ok pulse lasts one cycle because
   // the ok bits default to zero and are only set on the way into DONE.
   always_comb begin
      state_d    = state_q;
      rom_cs_d   = rom_cs_q;
      rom_addr_d = rom_addr_q;
      dout_d     = dout_q;
      ctrl_ok_d  = 1'b0;
      ch_ok_d    = 4'd0;
      rr_d       = rr_q;
      guard_d    = guard_q;
      gnt_ctrl_d = gnt_ctrl_q;
      gnt_ch_d   = gnt_ch_q;
`ifdef JT6295_ROM_CACHE_EN
      tag_d      = tag_q;
      cdata_d    = cdata_q;
      cvalid_d   = cvalid_q;
`endif
      case (state_q)
         IDLE: begin
            if (ctrl_cs) begin
               gnt_ctrl_d = 1'b1;
               rom_addr_d = {8'd0, ctrl_addr};
               rom_cs_d   = 1'b1;
               guard_d    = 1'b1;
               state_d    = WAIT;
            end else if (ch_any) begin
               gnt_ctrl_d = 1'b0;
               gnt_ch_d   = ch_sel;
`ifdef JT6295_ROM_CACHE_EN
               if (cache_hit) begin
                  dout_d          = cdata_q[ch_sel];
                  ch_ok_d[ch_sel] = 1'b1;
                  rr_d            = ch_sel;
                  state_d         = DONE;
               end else begin
                  rom_addr_d = ch_addr_arr[ch_sel];
                  rom_cs_d   = 1'b1;
                  guard_d    = 1'b1;
                  state_d    = WAIT;
               end
`else
               rom_addr_d = ch_addr_arr[ch_sel];
               rom_cs_d   = 1'b1;
               guard_d    = 1'b1;
               state_d    = WAIT;
`endif
            end
         end
         WAIT: begin
            guard_d = 1'b0;
            if (gnt_dropped) begin
               rom_cs_d = 1'b0;
               state_d  = IDLE;
            end else if (!guard_q && rom_ok) begin
               dout_d   = rom_data;
               rom_cs_d = 1'b0;
               state_d  = DONE;
               if (gnt_ctrl_q) begin
                  ctrl_ok_d = 1'b1;
               end else begin
                  ch_ok_d[gnt_ch_q] = 1'b1;
                  rr_d              = gnt_ch_q;
`ifdef JT6295_ROM_CACHE_EN
                  tag_d[gnt_ch_q]    = rom_addr_q;
                  cdata_d[gnt_ch_q]  = rom_data;
                  cvalid_d[gnt_ch_q] = 1'b1;
`endif
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. rr resets to 3 so that channel 0 is searched first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rom_cs_q   <= 1'b0;
         rom_addr_q <= 18'd0;
         dout_q     <= 8'd0;
         ctrl_ok_q  <= 1'b0;
         ch_ok_q    <= 4'd0;
         rr_q       <= 2'd3;
         guard_q    <= 1'b0;
         gnt_ctrl_q <= 1'b0;
         gnt_ch_q   <= 2'd0;
`ifdef JT6295_ROM_CACHE_EN
         for (int i = 0; i < 4; i++) begin
            tag_q[i]   <= 18'd0;
            cdata_q[i] <= 8'd0;
         end
         cvalid_q <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         rom_cs_q   <= rom_cs_d;
         rom_addr_q <= rom_addr_d;
         dout_q     <= dout_d;
         ctrl_ok_q  <= ctrl_ok_d;
         ch_ok_q    <= ch_ok_d;
         rr_q       <= rr_d;
         guard_q    <= guard_d;
         gnt_ctrl_q <= gnt_ctrl_d;
         gnt_ch_q   <= gnt_ch_d;
`ifdef JT6295_ROM_CACHE_EN
         tag_q    <= tag_d;
         cdata_q  <= cdata_d;
         cvalid_q <= cvalid_d;
`endif
      end
   end

   assign ctrl_ok  = ctrl_ok_q;
   assign ch_ok    = ch_ok_q;
   assign dout     = dout_q;
   assign rom_addr = rom_addr_q;
   assign rom_cs   = rom_cs_q;

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// tb_jt6295_rom_arb
// Self-checking bench for jt6295_rom_arb. The directed scenarios follow the
// documented cycle timing. A randomized run compares the DUT against a
// transaction-level model that tracks the round-robin pointer and the
// optional per-channel cache (JT6295_ROM_CACHE_EN).
module tb_jt6295_rom_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ctrl_cs;
   logic [9:0]  ctrl_addr;
   logic        ctrl_ok;
   logic [3:0]  ch_cs;
   logic [71:0] ch_addr;
   logic [3:0]  ch_ok;
   logic [7:0]  dout;
   logic [17:0] rom_addr;
   logic        rom_cs;
   logic [7:0]  rom_data;
   logic        rom_ok;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int          m_rr;
   logic [3:0]  m_valid;
   logic [17:0] m_tag  [4];
   logic [7:0]  m_data [4];
   logic [17:0] m_addr [4];

   jt6295_rom_arb dut (
      .clk       (clk),
      .rst       (rst),
      .ctrl_cs   (ctrl_cs),
      .ctrl_addr (ctrl_addr),
      .ctrl_ok   (ctrl_ok),
      .ch_cs     (ch_cs),
      .ch_addr   (ch_addr),
      .ch_ok     (ch_ok),
      .dout      (dout),
      .rom_addr  (rom_addr),
      .rom_cs    (rom_cs),
      .rom_data  (rom_data),
      .rom_ok    (rom_ok)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pack_addrs();
      for (int i = 0; i < 4; i++) ch_addr[18*i +: 18] = m_addr[i];
   endtask

   // First requesting channel after rr, wrapping round to rr itself last
   function automatic int pick(input logic [3:0] cs, input int rr);
      for (int k = 1; k <= 4; k++) begin
         if (cs[(rr + k) % 4]) return (rr + k) % 4;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      ctrl_cs = 1'b0; ctrl_addr = '0; ch_cs = '0; ch_addr = '0;
      rom_data = '0; rom_ok = 1'b0;
      tick(); tick();
      rst = 1'b0;
      m_rr = 3;
      m_valid = '0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (rom_cs !== 1'b0) begin failures++; $display("[TB] FAIL reset_rom_cs got=%h exp=0", rom_cs); end
      checks++; if (rom_addr !== 18'd0) begin failures++; $display("[TB] FAIL reset_rom_addr got=%h exp=0", rom_addr); end
      checks++; if (dout !== 8'd0) begin failures++; $display("[TB] FAIL reset_dout got=%h exp=0", dout); end
      checks++; if (ctrl_ok !== 1'b0) begin failures++; $display("[TB] FAIL reset_ctrl_ok got=%h exp=0", ctrl_ok); end
      checks++; if (ch_ok !== 4'd0) begin failures++; $display("[TB] FAIL reset_ch_ok got=%h exp=0", ch_ok); end
   endtask

   task automatic test_ctrl_read();
      do_reset();
      rom_ok = 1'b1; rom_data = 8'hA5;
      ctrl_addr = 10'h3F5; ctrl_cs = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         checks++;
         if (rom_cs !== ((c == 1) || (c == 2))) begin
            failures++; $display("[TB] FAIL ctrl_rom_cs cycle=%0d got=%h", c, rom_cs);
         end
         checks++;
         if (ctrl_ok !== (c == 3)) begin
            failures++; $display("[TB] FAIL ctrl_ok cycle=%0d got=%h", c, ctrl_ok);
         end
         if (c == 1) begin
            checks++;
            if (rom_addr !== 18'h003F5) begin failures++; $display("[TB] FAIL ctrl_rom_addr got=%h exp=003f5", rom_addr); end
         end
         if (c == 3) begin
            checks++;
            if (dout !== 8'hA5) begin failures++; $display("[TB] FAIL ctrl_dout got=%h exp=a5", dout); end
            ctrl_cs = 1'b0;
         end
      end
      rom_ok = 1'b0;
   endtask

   task automatic test_round_robin();
      int ev_cyc [6];
      int ev_ch  [6];
      int n_ev;
      logic [3:0] exp;
      do_reset();
      for (int i = 0; i < 4; i++) m_addr[i] = 18'($urandom);
      pack_addrs();
      rom_ok = 1'b1; rom_data = 8'h3C;
      ch_cs = 4'b1111;
`ifdef JT6295_ROM_CACHE_EN
      // Repeat accesses at the same address become cache hits
      ev_cyc = '{3, 7, 11, 15, 17, 19}; ev_ch = '{0, 1, 2, 3, 0, 1}; n_ev = 6;
`else
      ev_cyc = '{3, 7, 11, 15, 19, 0};  ev_ch = '{0, 1, 2, 3, 0, 0}; n_ev = 5;
`endif
      for (int c = 1; c <= 20; c++) begin
         tick();
         exp = 4'd0;
         for (int e = 0; e < n_ev; e++) if (ev_cyc[e] == c) exp[ev_ch[e]] = 1'b1;
         checks++;
         if ({ctrl_ok, ch_ok} !== {1'b0, exp}) begin
            failures++; $display("[TB] FAIL rr_ok cycle=%0d got=%b exp=%b", c, {ctrl_ok, ch_ok}, {1'b0, exp});
         end
      end
      ch_cs = 4'd0; rom_ok = 1'b0;
      tick(); tick(); tick(); tick();
   endtask

   task automatic test_ctrl_priority();
      do_reset();
      for (int i = 0; i < 4; i++) m_addr[i] = 18'($urandom);
      pack_addrs();
      rom_ok = 1'b0;
      ch_cs = 4'b0100;
      tick(); // cycle 1, ch2 in guard cycle
      checks++;
      if (rom_addr !== m_addr[2]) begin failures++; $display("[TB] FAIL prio_ch2_addr got=%h exp=%h", rom_addr, m_addr[2]); end
      ctrl_addr = 10'($urandom); ctrl_cs = 1'b1;
      tick(); // cycle 2
      rom_ok = 1'b1;
      tick(); // cycle 3
      checks++;
      if ({ctrl_ok, ch_ok} !== 5'b00100) begin failures++; $display("[TB] FAIL prio_ch2_ok got=%b exp=00100", {ctrl_ok, ch_ok}); end
      tick(); // cycle 4, IDLE with both ctrl and ch2 requesting
      checks++;
      if ({ctrl_ok, ch_ok} !== 5'b0) begin failures++; $display("[TB] FAIL prio_idle_ok got=%b exp=0", {ctrl_ok, ch_ok}); end
      tick(); // cycle 5
      checks++;
      if (rom_addr !== {8'd0, ctrl_addr} || rom_cs !== 1'b1) begin
         failures++; $display("[TB] FAIL prio_ctrl_grant addr=%h cs=%h exp_addr=%h", rom_addr, rom_cs, {8'd0, ctrl_addr});
      end
      tick(); tick(); // cycle 7
      checks++;
      if ({ctrl_ok, ch_ok} !== 5'b10000) begin failures++; $display("[TB] FAIL prio_ctrl_ok got=%b exp=10000", {ctrl_ok, ch_ok}); end
      ctrl_cs = 1'b0; ch_cs = 4'd0; rom_ok = 1'b0;
      tick();
   endtask

   task automatic test_rom_ok_delay();
      logic [7:0] x;
      do_reset();
      m_addr[0] = 18'($urandom); pack_addrs();
      ch_cs = 4'b0001; rom_ok = 1'b0;
      x = 8'h00;
      tick(); // cycle 1, glitch on rom_ok during the guard cycle
      rom_ok = 1'b1; rom_data = 8'($urandom);
      for (int c = 2; c <= 8; c++) begin
         tick();
         checks++;
         if (ch_ok !== ((c == 8) ? 4'b0001 : 4'b0000)) begin
            failures++; $display("[TB] FAIL delay_ok cycle=%0d got=%b", c, ch_ok);
         end
         checks++;
         if (rom_cs !== (c <= 7)) begin
            failures++; $display("[TB] FAIL delay_rom_cs cycle=%0d got=%h", c, rom_cs);
         end
         rom_ok = (c == 7);
         rom_data = 8'($urandom);
         if (c == 7) x = rom_data;
         if (c == 8) begin
            checks++;
            if (dout !== x) begin failures++; $display("[TB] FAIL delay_dout got=%h exp=%h", dout, x); end
            ch_cs = 4'd0;
         end
      end
      rom_ok = 1'b0;
      tick();
   endtask

   task automatic test_abort_reset();
      logic [7:0] d;
      do_reset();
      d = 8'($urandom_range(1, 255));
      ctrl_addr = 10'h011; ctrl_cs = 1'b1; rom_ok = 1'b1; rom_data = d;
      tick(); tick(); tick(); // cycle 3
      ctrl_cs = 1'b0;
      checks++;
      if (dout !== d) begin failures++; $display("[TB] FAIL abort_pre_dout got=%h exp=%h", dout, d); end
      tick(); // IDLE
      m_addr[1] = 18'($urandom); pack_addrs();
      ch_cs = 4'b0010; rom_ok = 1'b0;
      tick(); // cycle 1
      checks++;
      if (rom_cs !== 1'b1 || rom_addr !== m_addr[1]) begin
         failures++; $display("[TB] FAIL abort_grant cs=%h addr=%h exp_addr=%h", rom_cs, rom_addr, m_addr[1]);
      end
      tick(); // cycle 2
      ch_cs = 4'd0;
      tick(); // cycle 3
      checks++;
      if (rom_cs !== 1'b0 || ch_ok !== 4'd0 || dout !== d) begin
         failures++; $display("[TB] FAIL abort_result cs=%h ok=%b dout=%h exp_dout=%h", rom_cs, ch_ok, dout, d);
      end
      tick();
      checks++;
      if (ch_ok !== 4'd0) begin failures++; $display("[TB] FAIL abort_late_ok got=%b exp=0", ch_ok); end
      // Reset in the middle of an access
      ch_cs = 4'b0010;
      tick(); tick(); // cycle 2
      rst = 1'b1; rom_ok = 1'b1; rom_data = 8'hFF;
      tick(); // cycle 3
      rst = 1'b0; ch_cs = 4'd0; rom_ok = 1'b0;
      m_rr = 3; m_valid = '0;
      checks++;
      if ({rom_cs, rom_addr, dout, ctrl_ok, ch_ok} !== '0) begin
         failures++; $display("[TB] FAIL rst_mid cs=%h addr=%h dout=%h cok=%h chok=%b exp=0", rom_cs, rom_addr, dout, ctrl_ok, ch_ok);
      end
      tick();
      checks++;
      if ({ctrl_ok, ch_ok} !== 5'd0) begin failures++; $display("[TB] FAIL rst_mid_ok got=%b exp=0", {ctrl_ok, ch_ok}); end
   endtask

`ifdef JT6295_ROM_CACHE_EN
   task automatic test_cache();
      logic [7:0] d;
      do_reset();
      d = 8'($urandom);
      m_addr[3] = 18'h12345; pack_addrs();
      ch_cs = 4'b1000; rom_ok = 1'b1; rom_data = d;
      tick(); tick(); tick(); // cycle 3
      checks++;
      if (ch_ok !== 4'b1000 || dout !== d) begin failures++; $display("[TB] FAIL cache_first ok=%b dout=%h exp_dout=%h", ch_ok, dout, d); end
      ch_cs = 4'd0;
      tick(); // IDLE
      ch_cs = 4'b1000; rom_data = ~d;
      tick(); // cycle 1
      checks++;
      if (ch_ok !== 4'b1000 || rom_cs !== 1'b0 || dout !== d) begin
         failures++; $display("[TB] FAIL cache_hit ok=%b cs=%h dout=%h exp_dout=%h", ch_ok, rom_cs, dout, d);
      end
      ch_cs = 4'd0; rom_ok = 1'b0;
      tick();
   endtask
`endif

   task automatic test_random();
      int         win;
      int         d;
      logic [17:0] a;
      logic       hit;
      logic [7:0] x;
      logic [4:0] exp_ok;
      do_reset();
      for (int i = 0; i < 4; i++) m_addr[i] = 18'($urandom);
      for (int t = 0; t < 60; t++) begin
         ctrl_cs = ($urandom_range(0, 3) == 0);
         ctrl_addr = 10'($urandom);
         ch_cs = 4'($urandom);
         if (!ctrl_cs && ch_cs == 4'd0) ch_cs[$urandom_range(0, 3)] = 1'b1;
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 1) == 1) m_addr[i] = 18'($urandom);
         pack_addrs();
         rom_ok = 1'b0;
         hit = 1'b0;
         if (ctrl_cs) begin
            win = 4; a = {8'd0, ctrl_addr};
         end else begin
            win = pick(ch_cs, m_rr); a = m_addr[win];
`ifdef JT6295_ROM_CACHE_EN
            hit = m_valid[win] && (m_tag[win] == a);
`endif
         end
         exp_ok = 5'd0; exp_ok[win] = 1'b1;
         d = $urandom_range(0, 3);
         tick(); // cycle 1
         if (hit) begin
            checks++;
            if ({ctrl_ok, ch_ok} !== exp_ok || rom_cs !== 1'b0 || dout !== m_data[win]) begin
               failures++; $display("[TB] FAIL rand_hit t=%0d ok=%b exp=%b cs=%h dout=%h exp_dout=%h", t, {ctrl_ok, ch_ok}, exp_ok, rom_cs, dout, m_data[win]);
            end
            m_rr = win;
            ctrl_cs = 1'b0; ch_cs = 4'd0;
            tick();
            continue;
         end
         checks++;
         if (rom_cs !== 1'b1 || rom_addr !== a || {ctrl_ok, ch_ok} !== 5'd0) begin
            failures++; $display("[TB] FAIL rand_grant t=%0d cs=%h addr=%h exp_addr=%h ok=%b", t, rom_cs, rom_addr, a, {ctrl_ok, ch_ok});
         end
         rom_ok = 1'($urandom); rom_data = 8'($urandom);
         x = 8'h00;
         for (int k = 0; k <= d; k++) begin
            tick();
            checks++;
            if (rom_cs !== 1'b1 || {ctrl_ok, ch_ok} !== 5'd0) begin
               failures++; $display("[TB] FAIL rand_wait t=%0d k=%0d cs=%h ok=%b", t, k, rom_cs, {ctrl_ok, ch_ok});
            end
            rom_ok = (k == d);
            rom_data = 8'($urandom);
            if (k == d) x = rom_data;
         end
         tick(); // completion cycle
         checks++;
         if ({ctrl_ok, ch_ok} !== exp_ok || dout !== x || rom_cs !== 1'b0) begin
            failures++; $display("[TB] FAIL rand_done t=%0d ok=%b exp=%b dout=%h exp_dout=%h cs=%h", t, {ctrl_ok, ch_ok}, exp_ok, dout, x, rom_cs);
         end
         if (win < 4) begin
            m_rr = win;
            m_valid[win] = 1'b1; m_tag[win] = a; m_data[win] = x;
         end
         ctrl_cs = 1'b0; ch_cs = 4'd0; rom_ok = 1'b0;
         tick();
         checks++;
         if ({ctrl_ok, ch_ok} !== 5'd0) begin failures++; $display("[TB] FAIL rand_idle t=%0d ok=%b exp=0", t, {ctrl_ok, ch_ok}); end
      end
   endtask

   initial begin
      test_reset();
      test_ctrl_read();
      test_round_robin();
      test_ctrl_priority();
      test_rom_ok_delay();
      test_abort_reset();
`ifdef JT6295_ROM_CACHE_EN
      test_cache();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
